// File: rtl/stdio_pkg.sv
// rtl/stdio_pkg.sv - port map and constants shared by the stdio_port block
package stdio_pkg;

    localparam logic [8:0] PORT_STDIN      = 9'd2;
    localparam logic [8:0] PORT_STDOUT     = 9'd3;
    localparam logic [8:0] PORT_IRQ_STATUS = 9'd4;
    localparam logic [8:0] PORT_IRQ_MASK   = 9'd5;

    localparam int IRQ_RX = 0;
    localparam int IRQ_TX = 1;

    localparam logic [15:0] STDIN_EMPTY = 16'h8000;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with wrap-bit pointers
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Both qualifiers use pre-edge flags, so a pop never makes room for a same-cycle push.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q + {{(PW-1){1'b0}}, push_ok};
        rptr_d = rptr_q + {{(PW-1){1'b0}}, pop_ok};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/stdio_port.sv
// rtl/stdio_port.sv - CPU stdin/stdout/interrupt ports 2..5; STDIO_TX_FIFO_EN selects a TX FIFO over a holding register
module stdio_port
    import stdio_pkg::*;
#(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [8:0]  io_port,
    input  logic [15:0] data_out,
    input  logic        data_out_valid,
    output logic [15:0] data_in,
    output logic        irq,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready
);

    logic       cpu_wr_stdin;
    logic       cpu_wr_stdout;
    logic       cpu_wr_mask;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_head;
    logic       tx_space;
    logic [1:0] pending;
    logic [1:0] mask_q, mask_d;
    logic       irq_q, irq_d;
    logic       unused_ok;

    assign cpu_wr_stdin  = data_out_valid && (io_port == PORT_STDIN);
    assign cpu_wr_stdout = data_out_valid && (io_port == PORT_STDOUT);
    assign cpu_wr_mask   = data_out_valid && (io_port == PORT_IRQ_MASK);

    byte_fifo #(
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push_i (rx_valid),
        .pop_i  (cpu_wr_stdin),
        .wdata_i(rx_byte),
        .rdata_o(rx_head),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

    assign rx_ready = !rx_full;

`ifdef STDIO_TX_FIFO_EN
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;

    byte_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push_i (cpu_wr_stdout),
        .pop_i  (tx_valid && tx_ready),
        .wdata_i(data_out[7:0]),
        .rdata_o(tx_head),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    // The head slot is unreset storage, so present zero while nothing is queued.
    assign tx_valid  = !tx_empty;
    assign tx_byte   = tx_empty ? 8'h00 : tx_head;
    assign tx_space  = !tx_full;
    assign unused_ok = ^data_out[15:8];
`else
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_byte_q, tx_byte_d;

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        // Space is judged before the edge: an occupied register drops the write even if it drains now.
        if (cpu_wr_stdout && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = data_out[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_byte   = tx_byte_q;
    assign tx_space  = !tx_valid_q;
    assign unused_ok = ^{data_out[15:8], TX_DEPTH[0]};
`endif

    always_comb begin
        pending         = 2'b00;
        pending[IRQ_RX] = !rx_empty;
        pending[IRQ_TX] = tx_space;
    end

    always_comb begin
        mask_d = mask_q;
        if (cpu_wr_mask) begin
            mask_d = data_out[1:0];
        end
        irq_d = |(pending & mask_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        data_in = 16'h0000;
        case (io_port)
            PORT_STDIN:      data_in = rx_empty ? STDIN_EMPTY : {8'h00, rx_head};
            PORT_STDOUT:     data_in = {15'h0000, tx_space};
            PORT_IRQ_STATUS: data_in = {14'h0000, pending & mask_q};
            PORT_IRQ_MASK:   data_in = {14'h0000, mask_q};
            default:         data_in = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_stdio_port.sv
// tb/tb_stdio_port.sv - scoreboard bench for stdio_port (either STDIO_TX_FIFO_EN build)
module tb_stdio_port;

    localparam int RX_DEPTH = 8;
    localparam int TX_DEPTH = 4;

    localparam int SEL_DIN   = 0;
    localparam int SEL_IRQ   = 1;
    localparam int SEL_RXRDY = 2;
    localparam int SEL_TXV   = 3;
    localparam int SEL_TXB   = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [8:0]  io_port;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [15:0] data_in;
    logic        irq;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_exp_q[$];
    int         cyc_n   = 0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clock = ~clock;

    stdio_port #(
        .RX_DEPTH(RX_DEPTH),
        .TX_DEPTH(TX_DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .io_port       (io_port),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_in       (data_in),
        .irq           (irq),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_byte       (tx_byte),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready)
    );

    function automatic logic [15:0] sample(input int sel);
        case (sel)
            SEL_DIN:   return data_in;
            SEL_IRQ:   return {15'h0000, irq};
            SEL_RXRDY: return {15'h0000, rx_ready};
            SEL_TXV:   return {15'h0000, tx_valid};
            SEL_TXB:   return {8'h00, tx_byte};
            default:   return 16'hdead;
        endcase
    endfunction

    // Signal monitor: evaluates every expectation queued for the current cycle.
    always @(negedge clock) begin
        exp_t        e;
        logic [15:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
            e   = exp_q.pop_front();
            act = sample(e.sel);
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc_n);
            end
        end
    end

    // Transfer monitor: every downstream handshake must match the next queued byte.
    always @(negedge clock) begin
        logic [7:0] want;
        if (reset_n && tx_valid && tx_ready) begin
            n_tests++;
            if (tx_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got %h expected none", tx_byte);
            end else begin
                want = tx_exp_q.pop_front();
                if (tx_byte !== want) begin
                    n_fail++;
                    $display("FAIL tx_order: got %h expected %h", tx_byte, want);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    task automatic expect_sig(input int sel, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc_n;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [8:0] port, input logic [15:0] v, input string nm);
        io_port        = port;
        data_out_valid = 1'b0;
        expect_sig(SEL_DIN, v, nm);
        tick();
    endtask

    task automatic wr(input logic [8:0] port, input logic [15:0] d);
        io_port        = port;
        data_out       = d;
        data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
    endtask

    task automatic tx_wr(input logic [7:0] b, input bit accepted);
        if (accepted) tx_exp_q.push_back(b);
        wr(9'd3, {8'hee, b});
    endtask

    initial begin
        reset_n = 1'b0; io_port = '0; data_out = '0; data_out_valid = 1'b0;
        rx_byte = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Reset state
        expect_sig(SEL_IRQ, 16'h0000, "reset_irq");
        expect_sig(SEL_RXRDY, 16'h0001, "reset_rx_ready");
        expect_sig(SEL_TXV, 16'h0000, "reset_tx_valid");
        expect_sig(SEL_TXB, 16'h0000, "reset_tx_byte");
        rd(9'd2, 16'h8000, "reset_p2");
        rd(9'd3, 16'h0001, "reset_p3");
        rd(9'd4, 16'h0000, "reset_p4");
        rd(9'd5, 16'h0000, "reset_p5");
        rd(9'd0, 16'h0000, "other_p0");
        rd(9'h102, 16'h0000, "other_p258");

        // Single byte in and out
        rx_valid = 1'b1; rx_byte = 8'h41;
        tick();
        rx_valid = 1'b0;
        rd(9'd2, 16'h0041, "rx_41");
        wr(9'd2, 16'h0000);
        rd(9'd2, 16'h8000, "rx_popped");
        wr(9'd2, 16'h0000);
        rd(9'd2, 16'h8000, "pop_empty_ignored");

        // Fill past capacity
        for (int i = 0; i <= RX_DEPTH; i++) begin
            rx_valid = 1'b1; rx_byte = 8'h80 + 8'(i);
            expect_sig(SEL_RXRDY, (i < RX_DEPTH) ? 16'h0001 : 16'h0000, "fill_rx_ready");
            tick();
        end
        rx_byte = 8'h5a;
        expect_sig(SEL_RXRDY, 16'h0000, "full_pop_push_ready");
        wr(9'd2, 16'h0000);
        rx_valid = 1'b0;
        expect_sig(SEL_RXRDY, 16'h0001, "ready_after_pop");
        for (int k = 0; k < RX_DEPTH - 1; k++) begin
            logic [7:0] b;
            b = 8'h81 + 8'(k);
            rd(9'd2, {8'h00, b}, "drain_order");
            wr(9'd2, 16'h0000);
        end
        rd(9'd2, 16'h8000, "drain_empty");

        // Empty FIFO, push and pop together: byte kept
        rx_valid = 1'b1; rx_byte = 8'h33;
        wr(9'd2, 16'h0000);
        rx_valid = 1'b0;
        rd(9'd2, 16'h0033, "empty_push_pop");
        wr(9'd2, 16'h0000);

        // RX interrupt
        wr(9'd5, 16'hfffd);
        expect_sig(SEL_IRQ, 16'h0000, "irq_mask_only");
        rd(9'd5, 16'h0001, "mask_01");
        rx_valid = 1'b1; rx_byte = 8'h10;
        tick();
        rx_valid = 1'b0;
        expect_sig(SEL_IRQ, 16'h0000, "irq_not_yet");
        rd(9'd2, 16'h0010, "rx_10");
        expect_sig(SEL_IRQ, 16'h0001, "irq_rx_set");
        rd(9'd4, 16'h0001, "status_rx");
        wr(9'd4, 16'hffff);
        wr(9'd2, 16'h0000);
        expect_sig(SEL_IRQ, 16'h0001, "irq_still_set");
        rd(9'd4, 16'h0000, "status_cleared");
        expect_sig(SEL_IRQ, 16'h0000, "irq_rx_clear");
        tick();

        // TX-space interrupt
        wr(9'd5, 16'h0002);
        expect_sig(SEL_IRQ, 16'h0000, "irq_tx_pre");
        tick();
        expect_sig(SEL_IRQ, 16'h0001, "irq_tx_set");
        rd(9'd4, 16'h0002, "status_tx");
        wr(9'd5, 16'h0000);
        tick();
        expect_sig(SEL_IRQ, 16'h0000, "irq_tx_clear");
        rd(9'd5, 16'h0000, "mask_00");

`ifdef STDIO_TX_FIFO_EN
        tx_ready = 1'b0;
        tx_wr(8'ha1, 1'b1);
        expect_sig(SEL_TXB, 16'h00a1, "fifo_head");
        tx_wr(8'ha2, 1'b1);
        tx_wr(8'ha3, 1'b1);
        rd(9'd3, 16'h0001, "fifo_space_3");
        tx_wr(8'ha4, 1'b1);
        rd(9'd3, 16'h0000, "fifo_full");
        tx_wr(8'ha5, 1'b0);
        tx_ready = 1'b1;
        tx_wr(8'ha6, 1'b0);
`else
        tx_ready = 1'b0;
        tx_wr(8'h61, 1'b1);
        expect_sig(SEL_TXV, 16'h0001, "hold_valid");
        expect_sig(SEL_TXB, 16'h0061, "hold_byte");
        rd(9'd3, 16'h0000, "hold_no_space");
        tx_wr(8'h62, 1'b0);
        expect_sig(SEL_TXB, 16'h0061, "hold_byte_stable");
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        expect_sig(SEL_TXV, 16'h0000, "hold_drained");
        rd(9'd3, 16'h0001, "hold_space");
        tx_wr(8'h71, 1'b1);
        tx_ready = 1'b1;
        tx_wr(8'h72, 1'b0);
`endif
        tx_ready = 1'b1;
        for (int k = 0; k < 20 && tx_valid; k++) tick();
        expect_sig(SEL_TXV, 16'h0000, "tx_idle_after_drain");
        tick();
        tx_ready = 1'b0;

        // Asynchronous reset while loaded
        wr(9'd5, 16'h0001);
        rx_valid = 1'b1; rx_byte = 8'h11;
        tick();
        rx_byte = 8'h22;
        tick();
        rx_valid = 1'b0;
        tx_wr(8'h7e, 1'b1);
        expect_sig(SEL_IRQ, 16'h0001, "irq_before_reset");
        tick();
        reset_n = 1'b0;
        tx_exp_q.delete();
        expect_sig(SEL_IRQ, 16'h0000, "reset_mid_irq");
        expect_sig(SEL_TXV, 16'h0000, "reset_mid_tx_valid");
        expect_sig(SEL_TXB, 16'h0000, "reset_mid_tx_byte");
        expect_sig(SEL_RXRDY, 16'h0001, "reset_mid_rx_ready");
        rd(9'd2, 16'h8000, "reset_mid_p2");
        reset_n = 1'b1;
        rd(9'd2, 16'h8000, "post_reset_p2");
        rd(9'd5, 16'h0000, "post_reset_mask");
        tick();

        n_tests++;
        if (exp_q.size() != 0 || tx_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: got %0d/%0d expected 0/0", exp_q.size(), tx_exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stdio_port.md
# stdio_port

Platform-side standard I/O and interrupt block that sits directly on the CPU's I/O port and serves reserved ports 2 to 5.
- Port 2: standard input.
- Port 3: standard output.
- Port 4: interrupt status.
- Port 5: interrupt mask.

It buffers incoming bytes from an upstream byte source in a receive FIFO and hands outgoing bytes to a downstream byte sink. It supplies the CPU's combinational `data_in` read path and drives the CPU `irq` input.

## Interface
- `RX_DEPTH`, default 8: receive FIFO entries; must be a power of 2 and ≥ 2.
- `TX_DEPTH`, default 4: transmit FIFO entries; must be a power of 2 and ≥ 2. Used only with `STDIO_TX_FIFO_EN`.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `io_port`  in  9  CPU I/O port number.
- `data_out`  in  16  CPU write data.
- `data_out_valid`  in  1  CPU write strobe, valid for 1 clock.
- `data_in`  out  16  CPU read data; combinational from `io_port` and current state.
- `irq`  out  1  interrupt request to the CPU; registered.
- `rx_byte`  in  8  byte from upstream source.
- `rx_valid`  in  1  `rx_byte` valid.
- `rx_ready`  out  1  receive FIFO can accept.
- `tx_byte`  out  8  byte to downstream sink.
- `tx_valid`  out  1  `tx_byte` valid.
- `tx_ready`  in  1  sink accepts.

## Operation
**CPU writes and reads**
- A write is any cycle with `data_out_valid=1`; `io_port` selects the target.
- The CPU cannot be stalled. Every read and write completes in its own cycle.

**Port 2 (standard input)**
- Read:
  - FIFO non-empty: `{8'h00, head}`.
  - FIFO empty: `16'h8000`.
- Write: pops the head. A write while empty is ignored.

**Port 3 (standard output)**
- Read: `16'h0001` if TX space is available, else `16'h0000`.
- Write: pushes `data_out[7:0]` if space is available. If there is no space, the byte is silently dropped.

**Port 4 (interrupt status)**
- Read: `{14'b0, pending & mask}`.
- `pending[0]` = RX FIFO non-empty.
- `pending[1]` = TX space available.
- Writes are ignored.

**Port 5 (interrupt mask)**
- Read/write register; only bits [1:0] are stored.
- Read returns `{14'b0, mask}`.

**Other ports**
- Reads return `16'h0000`; writes are ignored.

**Receive path**
- A byte is pushed when `rx_valid && rx_ready`.
- `rx_ready = !rx_full`. It is derived from registered state only and does not depend on a pop in the same cycle.

**Transmit path**
- A byte is accepted downstream when `tx_valid && tx_ready`.

**Interrupt**
- `irq` is registered as the OR-reduction of `pending & mask`.

**Width rules**
- Pointers are `$clog2(depth)+1` bits; the MSB distinguishes full from empty.
- Pointers wrap modulo 2×depth.

**Boundary conditions**
- RX full, with a pop and `rx_valid` in the same cycle: the pop is performed and the push is refused. `rx_ready` rises the next cycle.
- RX empty, with a push and a pop write in the same cycle: the pop is ignored and the byte is stored.
- TX, with a CPU push and a downstream accept in the same cycle: space is judged on pre-edge state. If the buffer was full, the CPU byte is dropped even though the accept frees space.
- `reset_n` asserted mid-operation: all buffered bytes are lost immediately.

## Timing
- Reset values:
  - `rx_ready=1`, `tx_valid=0`, `tx_byte=8'h00`, `irq=0`.
  - Mask = 0.
  - All pointers = 0.
  - `data_in` follows reset state, so a port 2 read returns `16'h8000`.
- Read latency: 0 cycles (combinational). A read reflects state before the current edge.
- A write or pop takes effect at the edge where `data_out_valid` is sampled. It is visible to reads in the following cycle.
- RX byte pushed at edge N: readable on port 2 in cycle N+1. `irq` asserts at edge N+1 if `mask[0]` is set.
- TX byte written at edge N: `tx_valid=1` with that byte from cycle N+1. It holds stable until accepted.
- `irq` deasserts one cycle after `pending & mask` becomes 0.

## Configuration
- `STDIO_TX_FIFO_EN` defined:
  - TX is a `TX_DEPTH`-entry FIFO.
  - `tx_byte` is the head entry.
  - TX space = not full.
- `STDIO_TX_FIFO_EN` undefined:
  - TX is a single holding register.
  - `tx_valid` is its occupancy flag.
  - TX space = `!tx_valid`.
  - `TX_DEPTH` is ignored.

## Structure
- Package `stdio_pkg` holds:
  - Port constants: `PORT_STDIN=2`, `PORT_STDOUT=3`, `PORT_IRQ_STATUS=4`, `PORT_IRQ_MASK=5`.
  - Interrupt bit indices: `IRQ_RX=0`, `IRQ_TX=1`.
  - `STDIN_EMPTY=16'h8000`.
- Sub-module `byte_fifo`:
  - Parameters: depth.
  - Ports: push, pop, data in/out, full, empty.
  - Async active-low reset.
  - Instantiated for RX, and for TX when the macro is defined.

## Test plan
- Reset, then read ports 2/3/4/5 → `8000`/`0001`/`0000`/`0000`; `irq=0`; `rx_ready=1`.
- Push `8'h41` on RX, read port 2 → `0041`; write port 2, read port 2 → `8000`.
- Push `RX_DEPTH+1` bytes back-to-back → `rx_ready=0` after `RX_DEPTH` bytes, extra byte refused. Then pop and push `8'h5A` in the same cycle → pop done, push refused, `rx_ready=1` the next cycle.
- Set mask `2'b01`, push `8'h10` → `irq=1` one cycle after the byte becomes readable. Pop it → `irq=0` one cycle later.
- With `tx_ready=0`, write `8'h61` then `8'h62` on port 3 (macro undefined):
  - `tx_byte=61`, `tx_valid=1`.
  - `8'h62` is dropped.
  - Port 3 reads `0000`.
  - Raise `tx_ready` → one transfer, then `tx_valid=0`.
- Macro defined, `tx_ready=0`, write 4 bytes then a 5th → port 3 reads `0000` after the 4th and the 5th byte is lost. Drain → bytes emerge in order.
